// File: rtl/expansion_stream.sv
// expansion_stream: registered E-expansion of a half block XOR subkey.
// The result goes out in one beat or as one S-box chunk per beat.
module expansion_stream #(
   parameter  int GROUPS  = 8,
   parameter  int GROUP_W = 4,
   localparam int N  = GROUPS * GROUP_W,
   localparam int CW = GROUP_W + 2,
   localparam int EW = GROUPS * CW,
   localparam int IW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic [EW-1:0] in_key,
   input  logic          in_mode,
   output logic          par_valid,
   input  logic          par_ready,
   output logic [EW-1:0] par_data,
   output logic          chunk_valid,
   input  logic          chunk_ready,
   output logic [CW-1:0] chunk_data,
   output logic [IW-1:0] chunk_idx,
   output logic          chunk_last
);

   typedef enum logic [1:0] {
      IDLE,
      PAR,
      SER
   } state_t;

   state_t        state;
   logic [EW-1:0] res;
   logic [EW-1:0] expd;
   logic [IW-1:0] idx;
   logic          rdy_q;
   logic          pv_q;
   logic          cv_q;
   logic [CW-1:0] res_chunk [GROUPS];

   // Each group borrows one neighbour bit on each side, wrapping mod N.
   for (genvar g = 0; g < GROUPS; g++) begin : g_exp
      localparam int HI = (g * GROUP_W + GROUP_W) % N;
      localparam int LO = (g * GROUP_W + N - 1) % N;
      assign expd[g*CW +: CW] = {in_data[HI],
                                 in_data[g*GROUP_W +: GROUP_W],
                                 in_data[LO]};
      assign res_chunk[g] = res[g*CW +: CW];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         res   <= '0;
         idx   <= '0;
         rdy_q <= 1'b1;
         pv_q  <= 1'b0;
         cv_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && rdy_q) begin
                  res   <= expd ^ in_key;
                  rdy_q <= 1'b0;
                  if (in_mode) begin
                     state <= SER;
                     cv_q  <= 1'b1;
                     idx   <= IW'(GROUPS - 1);
                  end else begin
                     state <= PAR;
                     pv_q  <= 1'b1;
                  end
               end
            end
            PAR: begin
               if (par_ready) begin
                  state <= IDLE;
                  pv_q  <= 1'b0;
                  rdy_q <= 1'b1;
               end
            end
            SER: begin
               if (chunk_ready) begin
                  if (idx == '0) begin
                     state <= IDLE;
                     cv_q  <= 1'b0;
                     rdy_q <= 1'b1;
                  end else begin
                     idx <= idx - 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
               rdy_q <= 1'b1;
               pv_q  <= 1'b0;
               cv_q  <= 1'b0;
            end
         endcase
      end
   end

   // in_ready must fall the instant reset asserts, not at the next edge.
   assign in_ready    = rdy_q & rst_n;
   assign par_valid   = pv_q;
   assign par_data    = pv_q ? res : '0;
   assign chunk_valid = cv_q;
   assign chunk_data  = cv_q ? res_chunk[idx] : '0;
   assign chunk_idx   = idx;
   assign chunk_last  = cv_q & (idx == '0);

endmodule

// File: tb/tb_expansion_stream.sv
// tb_expansion_stream: directed checks of expansion_stream
// in parallel and serial modes, backpressure, reset, small params.
module tb_expansion_stream;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [47:0] in_key;
   logic        in_mode;
   logic        par_valid;
   logic        par_ready;
   logic [47:0] par_data;
   logic        chunk_valid;
   logic        chunk_ready;
   logic [5:0]  chunk_data;
   logic [2:0]  chunk_idx;
   logic        chunk_last;

   logic        s_in_valid;
   logic        s_in_ready;
   logic [7:0]  s_in_data;
   logic [15:0] s_in_key;
   logic        s_in_mode;
   logic        s_par_valid;
   logic        s_par_ready;
   logic [15:0] s_par_data;
   logic        s_chunk_valid;
   logic        s_chunk_ready;
   logic [3:0]  s_chunk_data;
   logic [1:0]  s_chunk_idx;
   logic        s_chunk_last;

   int n_chk;
   int n_fail;

   logic [5:0] exp1 [8];
   logic [5:0] exp2 [8];

   expansion_stream #(.GROUPS(8), .GROUP_W(4)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_key      (in_key),
      .in_mode     (in_mode),
      .par_valid   (par_valid),
      .par_ready   (par_ready),
      .par_data    (par_data),
      .chunk_valid (chunk_valid),
      .chunk_ready (chunk_ready),
      .chunk_data  (chunk_data),
      .chunk_idx   (chunk_idx),
      .chunk_last  (chunk_last)
   );

   expansion_stream #(.GROUPS(4), .GROUP_W(2)) u_small (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (s_in_valid),
      .in_ready    (s_in_ready),
      .in_data     (s_in_data),
      .in_key      (s_in_key),
      .in_mode     (s_in_mode),
      .par_valid   (s_par_valid),
      .par_ready   (s_par_ready),
      .par_data    (s_par_data),
      .chunk_valid (s_chunk_valid),
      .chunk_ready (s_chunk_ready),
      .chunk_data  (s_chunk_data),
      .chunk_idx   (s_chunk_idx),
      .chunk_last  (s_chunk_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  tag, got, want);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic par_txn(input string tag,
                          input logic [31:0] d,
                          input logic [47:0] k,
                          input logic [47:0] want);
      in_valid  = 1'b1;
      in_mode   = 1'b0;
      in_data   = d;
      in_key    = k;
      par_ready = 1'b1;
      check({tag, "_rdy0"}, in_ready, 1);
      cyc();
      in_valid = 1'b0;
      check({tag, "_pv"}, par_valid, 1);
      check({tag, "_pd"}, par_data, want);
      check({tag, "_rdy1"}, in_ready, 0);
      check({tag, "_cv"}, chunk_valid, 0);
      cyc();
      check({tag, "_pv_off"}, par_valid, 0);
      check({tag, "_pd_off"}, par_data, 0);
      check({tag, "_rdy2"}, in_ready, 1);
   endtask

   initial begin
      int exp_idx;
      int xfers;
      int stall;
      int cycles;

      n_chk  = 0;
      n_fail = 0;
      exp1 = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h20};
      exp2 = '{8'h03, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h28};

      rst_n         = 1'b0;
      in_valid      = 1'b0;
      in_data       = '0;
      in_key        = '0;
      in_mode       = 1'b0;
      par_ready     = 1'b0;
      chunk_ready   = 1'b0;
      s_in_valid    = 1'b0;
      s_in_data     = '0;
      s_in_key      = '0;
      s_in_mode     = 1'b0;
      s_par_ready   = 1'b0;
      s_chunk_ready = 1'b0;

      #3;
      check("rst_rdy", in_ready, 0);
      check("rst_pv", par_valid, 0);
      check("rst_cv", chunk_valid, 0);
      check("rst_pd", par_data, 0);
      check("rst_cd", chunk_data, 0);
      check("rst_idx", chunk_idx, 0);
      check("rst_last", chunk_last, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rel_rdy", in_ready, 1);

      par_txn("p1", 32'h0000_0001, 48'h0, 48'h8000_0000_0002);
      par_txn("p2", 32'h8000_0000, 48'h0, 48'h4000_0000_0001);
      par_txn("p3", 32'h0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);

      // parallel backpressure
      in_valid  = 1'b1;
      in_mode   = 1'b0;
      in_data   = 32'h0000_0001;
      in_key    = 48'h0;
      par_ready = 1'b0;
      cyc();
      in_valid = 1'b0;
      in_data  = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         check("pbp_pv", par_valid, 1);
         check("pbp_pd", par_data, 48'h8000_0000_0002);
         check("pbp_rdy", in_ready, 0);
         if (i == 2) par_ready = 1'b1;
         cyc();
      end
      check("pbp_done", par_valid, 0);

      // serial, no backpressure; a held in_valid waits for IDLE
      in_valid    = 1'b1;
      in_mode     = 1'b1;
      in_data     = 32'h0000_0001;
      in_key      = 48'h0;
      chunk_ready = 1'b1;
      par_ready   = 1'b1;
      cyc();
      in_mode = 1'b0;
      in_data = 32'hFFFF_FFFF;
      for (int k = 0; k < 8; k++) begin
         check("s1_cv", chunk_valid, 1);
         check("s1_idx", chunk_idx, 7 - k);
         check("s1_cd", chunk_data, exp1[7-k]);
         check("s1_last", chunk_last, (k == 7));
         check("s1_pv", par_valid, 0);
         check("s1_rdy", in_ready, 0);
         cyc();
      end
      check("s1_end_cv", chunk_valid, 0);
      check("s1_end_cd", chunk_data, 0);
      check("s1_end_rdy", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      check("s1_held_pv", par_valid, 1);
      check("s1_held_pd", par_data, 48'hFFFF_FFFF_FFFF);
      cyc();
      check("s1_held_done", par_valid, 0);

      // serial with stall at idx 5
      in_valid = 1'b1;
      in_mode  = 1'b1;
      in_data  = 32'h0000_0001;
      in_key   = {6'd8, 6'd7, 6'd6, 6'd5,
                  6'd4, 6'd3, 6'd2, 6'd1};
      cyc();
      in_valid = 1'b0;
      in_key   = '0;
      exp_idx = 7;
      xfers   = 0;
      stall   = 0;
      cycles  = 0;
      for (int c = 0; c < 20 && xfers < 8; c++) begin
         chunk_ready = !(exp_idx == 5 && stall < 3);
         #1;
         check("s2_cv", chunk_valid, 1);
         check("s2_idx", chunk_idx, exp_idx[2:0]);
         check("s2_cd", chunk_data, exp2[exp_idx]);
         if (chunk_ready) begin
            xfers++;
            exp_idx--;
         end else begin
            stall++;
         end
         cycles++;
         cyc();
      end
      check("s2_xfers", xfers, 8);
      check("s2_cycles", cycles, 11);
      check("s2_end_cv", chunk_valid, 0);
      check("s2_end_rdy", in_ready, 1);

      // reset mid-stream at idx 3
      in_valid    = 1'b1;
      in_mode     = 1'b1;
      in_data     = 32'h0000_0001;
      chunk_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) cyc();
      check("r_idx3", chunk_idx, 3);
      check("r_cv_pre", chunk_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("r_cv", chunk_valid, 0);
      check("r_rdy", in_ready, 0);
      check("r_cd", chunk_data, 0);
      check("r_idx", chunk_idx, 0);
      check("r_last", chunk_last, 0);
      check("r_pd", par_data, 0);
      cyc();
      rst_n = 1'b1;
      #1;
      check("r_rel_rdy", in_ready, 1);
      check("r_rel_cv", chunk_valid, 0);
      par_txn("rp", 32'h8000_0000, 48'h0, 48'h4000_0000_0001);

      // GROUPS=4, GROUP_W=2
      s_in_valid  = 1'b1;
      s_in_mode   = 1'b0;
      s_in_data   = 8'h01;
      s_in_key    = 16'h0;
      s_par_ready = 1'b1;
      check("sm_rdy", s_in_ready, 1);
      cyc();
      s_in_valid = 1'b0;
      check("sm_pv", s_par_valid, 1);
      check("sm_pd", s_par_data, 16'h8002);
      cyc();
      check("sm_done", s_par_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
